overlay_fade_scheduler: RTL and testbench

Sequences a full-screen overlay image (e.g. the game-over screen) over the live game render on the VGA path. Generates the downscaled overlay ROM address from DrawX/DrawY, runs a frame-counted fade-in / hold / fade-out state machine, and alpha-blends overlay palette colour with game colour into the registered RGB outputs. Sits between the game pixel mux, the overlay ROM/palette pair and the VGA output pins.

---
 rtl/overlay_fade_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_overlay_fade_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_fade_scheduler.sv
// ---------------------------------------------------------------------------
// overlay_fade_scheduler
//
// Fades a full-screen 160x120 overlay image (stretched 4x to 640x480) in and
// out over the live game render on the VGA path. Produces the overlay ROM
// address from the beam position, runs a frame-counted
// IDLE / FADE_IN / HOLD / FADE_OUT sequence and alpha-blends the overlay
// palette colour with the game colour into registered RGB outputs.
//
// Optional feature macro: OVERLAY_AUTO_DISMISS_EN
//   defined   : HOLD auto-exits to FADE_OUT once it has lasted HOLD_TIMEOUT
//               frames, with or without a dismiss pulse.
//   undefined : HOLD lasts until an accepted dismiss; HOLD_TIMEOUT unused.
//
// Parameters
//   FADE_FRAMES   frames per alpha step (>= 1)
//   MIN_HOLD      frames fully shown before a dismiss is accepted
//   HOLD_TIMEOUT  HOLD frames before auto-dismiss (macro builds only)
//
// Ports
//   vga_clk            in   pixel clock, all state on posedge
//   Reset              in   synchronous, active-high
//   DrawX, DrawY       in   current beam column / row (10 bits each)
//   blank              in   1 = active video, 0 = blanking
//   trigger            in   one-cycle pulse, bring the overlay up
//   dismiss            in   one-cycle pulse, take the overlay down
//   game_r/g/b         in   game pixel colour for current DrawX/DrawY
//   ov_r/g/b           in   overlay palette colour (ROM read on negedge)
//   ov_rom_address     out  overlay ROM address (combinational, 15 bits)
//   red/green/blue     out  registered VGA colour, one clock after DrawX/Y
//   ov_active          out  sequencer not idle
//   ov_state           out  IDLE=0, FADE_IN=1, HOLD=2, FADE_OUT=3
// ---------------------------------------------------------------------------
module overlay_fade_scheduler #(
  parameter int unsigned FADE_FRAMES  = 4,
  parameter int unsigned MIN_HOLD     = 60,
  parameter int unsigned HOLD_TIMEOUT = 600
) (
  input  logic        vga_clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        trigger,
  input  logic        dismiss,
  input  logic [3:0]  game_r,
  input  logic [3:0]  game_g,
  input  logic [3:0]  game_b,
  input  logic [3:0]  ov_r,
  input  logic [3:0]  ov_g,
  input  logic [3:0]  ov_b,
  output logic [14:0] ov_rom_address,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        ov_active,
  output logic [1:0]  ov_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FADE_IN  = 2'd1,
    S_HOLD     = 2'd2,
    S_FADE_OUT = 2'd3
  } state_t;

`ifdef OVERLAY_AUTO_DISMISS_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  // The hold counter only needs to count as far as the largest threshold it
  // is ever compared against, then it sits there.
  localparam int unsigned HOLD_CAP = AUTO_EN ?
      ((HOLD_TIMEOUT > MIN_HOLD) ? HOLD_TIMEOUT : MIN_HOLD) : MIN_HOLD;
  localparam int unsigned HC_W  = (HOLD_CAP < 1) ? 1 : $clog2(HOLD_CAP + 1);
  localparam int unsigned SUB_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(FADE_FRAMES - 1);
  localparam logic [HC_W-1:0]  HOLD_SAT   = HC_W'(HOLD_CAP);
  localparam logic [HC_W-1:0]  MIN_HOLD_C = HC_W'(MIN_HOLD);
`ifdef OVERLAY_AUTO_DISMISS_EN
  localparam logic [HC_W-1:0]  HOLD_TO_C  = HC_W'(HOLD_TIMEOUT);
`endif

  // Per-channel blend: (ov*alpha + game*(16-alpha)) >> 4. The sum never
  // exceeds 15*16 = 240, so an 8-bit accumulator is exact; alpha=16 yields
  // ov and alpha=0 yields game with no rounding error.
  function automatic logic [3:0] f_blend(input logic [3:0] ov,
                                         input logic [3:0] game,
                                         input logic [4:0] alpha);
    logic [4:0] inv;
    logic [7:0] acc;
    inv = 5'd16 - alpha;
    acc = ({4'b0, ov} * {3'b0, alpha}) + ({4'b0, game} * {3'b0, inv});
    return acc[7:4];
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_alpha;
  logic [4:0]       w_alpha_nxt;
  logic [SUB_W-1:0] r_sub;
  logic [SUB_W-1:0] w_sub_nxt;
  logic [HC_W-1:0]  r_hold_cnt;
  logic [HC_W-1:0]  w_hold_nxt;
  logic [3:0]       r_red_p1;
  logic [3:0]       r_green_p1;
  logic [3:0]       r_blue_p1;

  logic [7:0]       w_row;
  logic [7:0]       w_col;
  logic [14:0]      w_row15;
  logic             w_tick;
  logic             w_sub_wrap;
  logic [HC_W-1:0]  w_hold_inc;

  // ---- stage p0: beam position -> ROM address, frame tick ----------------
  assign w_row   = DrawY[9:2];
  assign w_col   = DrawX[9:2];
  assign w_row15 = {7'b0, w_row};
  // row*160 as row*128 + row*32
  assign ov_rom_address = (w_row15 << 7) + (w_row15 << 5) + {7'b0, w_col};

  // First pixel of the first blanked line: alpha only moves here, so a
  // visible frame is always drawn with one constant alpha.
  assign w_tick = (DrawX == 10'd0) && (DrawY == 10'd480);

  assign w_sub_wrap = (r_sub == SUB_LAST);
  assign w_hold_inc = (r_hold_cnt == HOLD_SAT) ? r_hold_cnt : r_hold_cnt + 1'b1;

  // Next-state logic. Any state change requested by a pulse takes priority
  // over a coincident tick, so the alpha step is skipped that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_alpha_nxt = r_alpha;
    w_sub_nxt   = r_sub;
    w_hold_nxt  = r_hold_cnt;
    unique case (r_state)
      S_IDLE: begin
        w_alpha_nxt = 5'd0;
        if (trigger) begin
          w_state_nxt = S_FADE_IN;
          w_sub_nxt   = '0;
        end
      end
      S_FADE_IN: begin
        if (w_tick) begin
          if (w_sub_wrap) begin
            w_alpha_nxt = r_alpha + 5'd1;
            w_sub_nxt   = '0;
            if (r_alpha == 5'd15) begin
              w_state_nxt = S_HOLD;
              w_hold_nxt  = '0;
            end
          end else begin
            w_sub_nxt = r_sub + 1'b1;
          end
        end
      end
      S_HOLD: begin
        // A dismiss before MIN_HOLD frames is simply dropped.
        if (dismiss && (r_hold_cnt >= MIN_HOLD_C)) begin
          w_state_nxt = S_FADE_OUT;
          w_sub_nxt   = '0;
        end else if (w_tick) begin
          w_hold_nxt = w_hold_inc;
`ifdef OVERLAY_AUTO_DISMISS_EN
          if (w_hold_inc == HOLD_TO_C) begin
            w_state_nxt = S_FADE_OUT;
            w_sub_nxt   = '0;
          end
`endif
        end
      end
      S_FADE_OUT: begin
        // Re-trigger reverses from the current level rather than restarting.
        if (trigger) begin
          w_state_nxt = S_FADE_IN;
          w_sub_nxt   = '0;
        end else if (w_tick) begin
          if (w_sub_wrap) begin
            w_alpha_nxt = r_alpha - 5'd1;
            w_sub_nxt   = '0;
            if (r_alpha == 5'd1) begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_sub_nxt = r_sub + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_alpha_nxt = 5'd0;
      end
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_alpha    <= 5'd0;
      r_sub      <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_alpha    <= w_alpha_nxt;
      r_sub      <= w_sub_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // ---- stage p1: blended colour register ---------------------------------
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_red_p1   <= 4'd0;
      r_green_p1 <= 4'd0;
      r_blue_p1  <= 4'd0;
    end else if (blank) begin
      r_red_p1   <= f_blend(ov_r, game_r, r_alpha);
      r_green_p1 <= f_blend(ov_g, game_g, r_alpha);
      r_blue_p1  <= f_blend(ov_b, game_b, r_alpha);
    end else begin
      r_red_p1   <= 4'd0;
      r_green_p1 <= 4'd0;
      r_blue_p1  <= 4'd0;
    end
  end

  assign red       = r_red_p1;
  assign green     = r_green_p1;
  assign blue      = r_blue_p1;
  assign ov_state  = r_state;
  assign ov_active = (r_state != S_IDLE);

endmodule

// File: tb/tb_overlay_fade_scheduler.sv
// ---------------------------------------------------------------------------
// tb_overlay_fade_scheduler
//
// Directed bench for overlay_fade_scheduler with FADE_FRAMES=1, MIN_HOLD=2,
// HOLD_TIMEOUT=3. Colour inputs are fixed so the output reveals alpha:
//   red   : game 0,  ov 15
//   green : game 15, ov 0
//   blue  : game 8,  ov 0
// Frame ticks are produced by parking the beam at DrawX=0, DrawY=480.
// ---------------------------------------------------------------------------
module tb_overlay_fade_scheduler;

  logic        vga_clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        trigger;
  logic        dismiss;
  logic [3:0]  game_r, game_g, game_b;
  logic [3:0]  ov_r, ov_g, ov_b;
  logic [14:0] ov_rom_address;
  logic [3:0]  red, green, blue;
  logic        ov_active;
  logic [1:0]  ov_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 vga_clk = ~vga_clk;

  overlay_fade_scheduler #(
    .FADE_FRAMES (1),
    .MIN_HOLD    (2),
    .HOLD_TIMEOUT(3)
  ) dut (
    .vga_clk       (vga_clk),
    .Reset         (Reset),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .blank         (blank),
    .trigger       (trigger),
    .dismiss       (dismiss),
    .game_r        (game_r),
    .game_g        (game_g),
    .game_b        (game_b),
    .ov_r          (ov_r),
    .ov_g          (ov_g),
    .ov_b          (ov_b),
    .ov_rom_address(ov_rom_address),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .ov_active     (ov_active),
    .ov_state      (ov_state)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int blend_ref(input int ov, input int game, input int a);
    return (ov * a + game * (16 - a)) / 16;
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 ns after posedge.
  task automatic cyc();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic tick();
    DrawX = 10'd0; DrawY = 10'd480; blank = 1'b0;
    cyc();
    DrawX = 10'd100; DrawY = 10'd100; blank = 1'b1;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1; cyc(); trigger = 1'b0;
  endtask

  task automatic pulse_dismiss();
    dismiss = 1'b1; cyc(); dismiss = 1'b0;
  endtask

  // One active-video pixel, then compare all channels against alpha a.
  task automatic px(input string tag, input int a);
    DrawX = 10'd100; DrawY = 10'd100; blank = 1'b1;
    cyc();
    check_val({tag, "_r"}, int'(red),   blend_ref(15, 0, a));
    check_val({tag, "_g"}, int'(green), blend_ref(0, 15, a));
    check_val({tag, "_b"}, int'(blue),  blend_ref(0, 8, a));
  endtask

  initial begin
    Reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0;
    trigger = 1'b0; dismiss = 1'b0;
    game_r = 4'h0; ov_r = 4'hF;
    game_g = 4'hF; ov_g = 4'h0;
    game_b = 4'h8; ov_b = 4'h0;
    cyc(); cyc();
    check_val("rst_state",  int'(ov_state),  0);
    check_val("rst_active", int'(ov_active), 0);
    check_val("rst_red",    int'(red),   0);
    check_val("rst_green",  int'(green), 0);
    check_val("rst_blue",   int'(blue),  0);
    Reset = 1'b0;

    // ROM address corners
    DrawX = 10'd639; DrawY = 10'd479; #1;
    check_val("addr_max", int'(ov_rom_address), 19199);
    DrawX = 10'd5; DrawY = 10'd9; #1;
    check_val("addr_5_9", int'(ov_rom_address), 321);
    DrawX = 10'd0; DrawY = 10'd0; #1;
    check_val("addr_0_0", int'(ov_rom_address), 0);

    // Idle shows the game colour; a tick alone does nothing
    px("idle", 0);
    tick();
    check_val("idle_tick_state", int'(ov_state), 0);

    // Trigger coincident with tick: enter FADE_IN with no alpha step
    DrawX = 10'd0; DrawY = 10'd480; blank = 1'b0; trigger = 1'b1;
    cyc();
    trigger = 1'b0;
    check_val("trig_state",  int'(ov_state),  1);
    check_val("trig_active", int'(ov_active), 1);
    px("fin0", 0);

    // Fade in: one alpha step per tick, HOLD on reaching 16
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_val($sformatf("fin_state%0d", k), int'(ov_state), (k == 16) ? 2 : 1);
      px($sformatf("fin%0d", k), k);
      if (k == 5) begin
        pulse_trigger();
        check_val("fin_trig_ignored", int'(ov_state), 1);
        pulse_dismiss();
        check_val("fin_dism_ignored", int'(ov_state), 1);
        px("fin5_again", 5);
      end
    end

    // HOLD: trigger ignored, blanking forces black, early dismiss dropped
    pulse_trigger();
    check_val("hold_trig_ignored", int'(ov_state), 2);
    blank = 1'b0; cyc();
    check_val("blank_red",   int'(red),   0);
    check_val("blank_green", int'(green), 0);
    check_val("blank_blue",  int'(blue),  0);
    tick();
    pulse_dismiss();
    check_val("hold_early_dismiss", int'(ov_state), 2);
    tick();
    pulse_dismiss();
    check_val("hold_dismiss_ok", int'(ov_state), 3);
    px("fout16", 16);

    // Fade out to 9, then reverse
    for (int k = 15; k >= 9; k--) begin
      tick();
      check_val($sformatf("fout_state%0d", k), int'(ov_state), 3);
      px($sformatf("fout%0d", k), k);
    end
    pulse_trigger();
    check_val("rev_state", int'(ov_state), 1);
    px("rev9", 9);
    tick();
    check_val("rev_tick_state", int'(ov_state), 1);
    px("rev10", 10);
    for (int k = 11; k <= 16; k++) begin
      tick();
    end
    check_val("rehold_state", int'(ov_state), 2);
    tick(); tick();
    pulse_dismiss();
    check_val("redismiss_state", int'(ov_state), 3);

    // Full fade out to IDLE
    for (int k = 15; k >= 0; k--) begin
      tick();
      check_val($sformatf("fout2_state%0d", k), int'(ov_state), (k == 0) ? 0 : 3);
      px($sformatf("fout2_%0d", k), k);
      if (k == 4) check_val("blue_a4", int'(blue), 6);
    end
    check_val("end_active", int'(ov_active), 0);

    // Reset in the middle of a fade-in at alpha 7
    pulse_trigger();
    for (int k = 1; k <= 7; k++) tick();
    px("pre_rst7", 7);
    check_val("pre_rst_red", int'(red), 6);
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    check_val("mid_rst_state",  int'(ov_state),  0);
    check_val("mid_rst_active", int'(ov_active), 0);
    check_val("mid_rst_red",    int'(red),   0);
    check_val("mid_rst_green",  int'(green), 0);
    cyc();
    check_val("post_rst_red",   int'(red),   0);
    check_val("post_rst_green", int'(green), 15);
    check_val("post_rst_blue",  int'(blue),  8);

    // HOLD with no dismiss
    pulse_trigger();
    for (int k = 1; k <= 16; k++) tick();
    check_val("hold2_state", int'(ov_state), 2);
`ifdef OVERLAY_AUTO_DISMISS_EN
    tick(); tick();
    check_val("auto_hold_2ticks", int'(ov_state), 2);
    tick();
    check_val("auto_fout_3ticks", int'(ov_state), 3);
`else
    for (int k = 1; k <= 12; k++) tick();
    check_val("hold_persist", int'(ov_state), 2);
    px("hold_persist", 16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
